// File: rtl/rx_req_cpl_router.sv
// rx_req_cpl_router
// -----------------------------------------------------------------------------
// Sits in front of the 128-bit RX port. Read requests from the port are given
// a PCIe tag from a small pool and forwarded to the TX engine. Returning
// completions are matched against the tag table and steered onto the shared
// ENG_DATA bus with the MAIN / SG_RX / SG_TX enable, done and error strobes.
//
// Ports
//   CLK, rRst               clock; asynchronous active-high reset
//   RX_REQ*                 request from the RX port (ACK is a 1-cycle pulse)
//   RD_REQ*                 request to the TX engine (tag, addr, len)
//   CPL_*                   completion beats from the RX engine
//   ENG_DATA                completion payload, one cycle after CPL_VALID
//   *_DATA_EN/_DONE/_ERR    per-destination strobes, registered
//   CPL_DROP                completion hit a tag that is not allocated
//   IDLE                    request FSM idle and no tag outstanding
//   DBG_REQ_STATE           request FSM state (0 = IDLE, 1 = ISSUE)
//
// Handshakes:
//   RX_REQ/RX_REQ_ACK : the port holds RX_REQ and its fields stable until it
//     sees the registered ACK pulse. The cycle after an ACK is never used to
//     accept, so a request still visible in that cycle is not taken twice.
//   RD_REQ/RD_REQ_ACK : RD_REQ and its fields stay stable until the cycle in
//     which RD_REQ_ACK is 1; RD_REQ drops on the following edge.
// -----------------------------------------------------------------------------
module rx_req_cpl_router #(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_TAGS       = 8,
  parameter int C_TAG_WIDTH  = 3
) (
  input  logic                    CLK,
  input  logic                    rRst,
  input  logic                    RX_REQ,
  output logic                    RX_REQ_ACK,
  input  logic [1:0]              RX_REQ_TAG,
  input  logic [63:0]             RX_REQ_ADDR,
  input  logic [9:0]              RX_REQ_LEN,
  output logic                    RD_REQ,
  input  logic                    RD_REQ_ACK,
  output logic [C_TAG_WIDTH-1:0]  RD_REQ_TAG,
  output logic [63:0]             RD_REQ_ADDR,
  output logic [9:0]              RD_REQ_LEN,
  input  logic                    CPL_VALID,
  input  logic [C_TAG_WIDTH-1:0]  CPL_TAG,
  input  logic [C_DATA_WIDTH-1:0] CPL_DATA,
  input  logic [2:0]              CPL_DATA_EN,
  input  logic                    CPL_ERR,
  output logic [C_DATA_WIDTH-1:0] ENG_DATA,
  output logic [2:0]              MAIN_DATA_EN,
  output logic [2:0]              SG_RX_DATA_EN,
  output logic [2:0]              SG_TX_DATA_EN,
  output logic                    MAIN_DONE,
  output logic                    SG_RX_DONE,
  output logic                    SG_TX_DONE,
  output logic                    MAIN_ERR,
  output logic                    SG_RX_ERR,
  output logic                    SG_TX_ERR,
  output logic                    CPL_DROP,
  output logic                    IDLE,
  output logic                    DBG_REQ_STATE
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } req_state_e;

  localparam logic [1:0] DEST_MAIN    = 2'd0;
  localparam logic [1:0] DEST_SG_RX   = 2'd1;
  localparam logic [1:0] DEST_SG_TX   = 2'd2;
  localparam logic [1:0] DEST_INVALID = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  req_state_e              state_q, state_d;
  logic                    ack_q, ack_d;
  logic                    rd_req_q, rd_req_d;
  logic [C_TAG_WIDTH-1:0]  rd_tag_q, rd_tag_d;
  logic [63:0]             rd_addr_q, rd_addr_d;
  logic [9:0]              rd_len_q, rd_len_d;

  logic [C_TAGS-1:0]       valid_q, valid_d;
  logic [1:0]              dest_q [C_TAGS];
  logic [1:0]              dest_d [C_TAGS];
  logic [10:0]             rem_q  [C_TAGS];
  logic [10:0]             rem_d  [C_TAGS];

  logic [C_DATA_WIDTH-1:0] eng_data_q, eng_data_d;
  logic [2:0]              main_en_q, main_en_d;
  logic [2:0]              sg_rx_en_q, sg_rx_en_d;
  logic [2:0]              sg_tx_en_q, sg_tx_en_d;
  logic                    main_done_q, main_done_d;
  logic                    sg_rx_done_q, sg_rx_done_d;
  logic                    sg_tx_done_q, sg_tx_done_d;
  logic                    main_err_q, main_err_d;
  logic                    sg_rx_err_q, sg_rx_err_d;
  logic                    sg_tx_err_q, sg_tx_err_d;
  logic                    drop_q, drop_d;

  // ---------------------------------------------------------------------------
  // Lowest-numbered free tag, from the table as it stands before this cycle's
  // retire. A tag freed by a completion is therefore first usable next cycle.
  // ---------------------------------------------------------------------------
  logic                   free_found;
  logic [C_TAG_WIDTH-1:0] free_tag;

  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    for (int i = C_TAGS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_tag   = C_TAG_WIDTH'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  logic alloc;

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    rd_req_d  = rd_req_q;
    rd_tag_d  = rd_tag_q;
    rd_addr_d = rd_addr_q;
    rd_len_d  = rd_len_q;
    alloc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RX_REQ && !ack_q) begin
          if (RX_REQ_TAG == DEST_INVALID) begin
            ack_d = 1'b1;
          end else if (free_found) begin
            ack_d     = 1'b1;
            alloc     = 1'b1;
            rd_req_d  = 1'b1;
            rd_tag_d  = free_tag;
            rd_addr_d = RX_REQ_ADDR;
            rd_len_d  = RX_REQ_LEN;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (RD_REQ_ACK) begin
          rd_req_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Completion path and tag table update
  // ---------------------------------------------------------------------------
  logic [10:0] cpl_en11;
  logic [10:0] cpl_rem;
  logic [10:0] cpl_rem_new;
  logic        cpl_bad;
  logic        cpl_retire;
  logic [2:0]  sel_en;
  logic        sel_done;
  logic        sel_err;

  always_comb begin
    cpl_en11    = {8'd0, CPL_DATA_EN};
    cpl_rem     = rem_q[CPL_TAG];
    cpl_rem_new = cpl_rem - cpl_en11;
    cpl_bad     = CPL_ERR || (cpl_en11 > cpl_rem);
    cpl_retire  = cpl_bad || (cpl_rem_new == 11'd0);
    sel_en      = 3'd0;
    sel_done    = 1'b0;
    sel_err     = 1'b0;

    eng_data_d   = eng_data_q;
    main_en_d    = 3'd0;
    sg_rx_en_d   = 3'd0;
    sg_tx_en_d   = 3'd0;
    main_done_d  = 1'b0;
    sg_rx_done_d = 1'b0;
    sg_tx_done_d = 1'b0;
    main_err_d   = 1'b0;
    sg_rx_err_d  = 1'b0;
    sg_tx_err_d  = 1'b0;
    drop_d       = 1'b0;

    valid_d = valid_q;
    dest_d  = dest_q;
    rem_d   = rem_q;

    // Allocation only touches a free entry and a completion only touches a
    // valid one, so both updates can land in the same cycle.
    if (alloc) begin
      valid_d[free_tag] = 1'b1;
      dest_d[free_tag]  = RX_REQ_TAG;
      rem_d[free_tag]   = (RX_REQ_LEN == 10'd0) ? 11'd1024 : {1'b0, RX_REQ_LEN};
    end

    if (CPL_VALID) begin
      eng_data_d = CPL_DATA;
      if (!valid_q[CPL_TAG]) begin
        drop_d = 1'b1;
      end else begin
        sel_en   = cpl_bad ? 3'd0 : CPL_DATA_EN;
        sel_done = cpl_retire;
        sel_err  = cpl_bad;
        if (cpl_retire) begin
          valid_d[CPL_TAG] = 1'b0;
        end else begin
          rem_d[CPL_TAG] = cpl_rem_new;
        end
        case (dest_q[CPL_TAG])
          DEST_MAIN: begin
            main_en_d   = sel_en;
            main_done_d = sel_done;
            main_err_d  = sel_err;
          end
          DEST_SG_RX: begin
            sg_rx_en_d   = sel_en;
            sg_rx_done_d = sel_done;
            sg_rx_err_d  = sel_err;
          end
          DEST_SG_TX: begin
            sg_tx_en_d   = sel_en;
            sg_tx_done_d = sel_done;
            sg_tx_err_d  = sel_err;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge rRst) begin
    if (rRst) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_tag_q     <= '0;
      rd_addr_q    <= '0;
      rd_len_q     <= '0;
      valid_q      <= '0;
      for (int i = 0; i < C_TAGS; i++) begin
        dest_q[i] <= '0;
        rem_q[i]  <= '0;
      end
      eng_data_q   <= '0;
      main_en_q    <= '0;
      sg_rx_en_q   <= '0;
      sg_tx_en_q   <= '0;
      main_done_q  <= 1'b0;
      sg_rx_done_q <= 1'b0;
      sg_tx_done_q <= 1'b0;
      main_err_q   <= 1'b0;
      sg_rx_err_q  <= 1'b0;
      sg_tx_err_q  <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      rd_req_q     <= rd_req_d;
      rd_tag_q     <= rd_tag_d;
      rd_addr_q    <= rd_addr_d;
      rd_len_q     <= rd_len_d;
      valid_q      <= valid_d;
      dest_q       <= dest_d;
      rem_q        <= rem_d;
      eng_data_q   <= eng_data_d;
      main_en_q    <= main_en_d;
      sg_rx_en_q   <= sg_rx_en_d;
      sg_tx_en_q   <= sg_tx_en_d;
      main_done_q  <= main_done_d;
      sg_rx_done_q <= sg_rx_done_d;
      sg_tx_done_q <= sg_tx_done_d;
      main_err_q   <= main_err_d;
      sg_rx_err_q  <= sg_rx_err_d;
      sg_tx_err_q  <= sg_tx_err_d;
      drop_q       <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign RX_REQ_ACK    = ack_q;
  assign RD_REQ        = rd_req_q;
  assign RD_REQ_TAG    = rd_tag_q;
  assign RD_REQ_ADDR   = rd_addr_q;
  assign RD_REQ_LEN    = rd_len_q;
  assign ENG_DATA      = eng_data_q;
  assign MAIN_DATA_EN  = main_en_q;
  assign SG_RX_DATA_EN = sg_rx_en_q;
  assign SG_TX_DATA_EN = sg_tx_en_q;
  assign MAIN_DONE     = main_done_q;
  assign SG_RX_DONE    = sg_rx_done_q;
  assign SG_TX_DONE    = sg_tx_done_q;
  assign MAIN_ERR      = main_err_q;
  assign SG_RX_ERR     = sg_rx_err_q;
  assign SG_TX_ERR     = sg_tx_err_q;
  assign CPL_DROP      = drop_q;
  assign IDLE          = (state_q == S_IDLE) && (valid_q == '0);
  assign DBG_REQ_STATE = state_q;

endmodule

// File: doc/rx_req_cpl_router.md
Name: rx_req_cpl_router

Overview:
- Sits directly upstream of the 128-bit RX port.
- Accepts the port's read requests (RX_REQ/ACK/TAG/ADDR/LEN) and allocates a PCIe tag from a small pool. Issues the request to the TX engine.
- Tracks outstanding dwords per tag and steers returning completion data onto the shared ENG_DATA bus with the MAIN, SG_RX or SG_TX enable/done/err strobes the RX port consumes.

Parameters:
- C_DATA_WIDTH, 128, completion/engine data width (4 dwords).
- C_TAGS, 8, number of PCIe tags in the pool (power of 2, 2..32).
- C_TAG_WIDTH, 3, log2(C_TAGS).

Ports:
- CLK  in  1  clock
- rRst  in  1  reset; asynchronous, active-high
- RX_REQ  in  1  read request from RX port
- RX_REQ_ACK  out  1  request accepted (1-cycle pulse)
- RX_REQ_TAG  in  2  destination: 0=MAIN, 1=SG_RX, 2=SG_TX, 3=invalid
- RX_REQ_ADDR  in  64  read address
- RX_REQ_LEN  in  10  length in dwords, 0 means 1024
- RD_REQ  out  1  read request to TX engine
- RD_REQ_ACK  in  1  TX engine accepted request
- RD_REQ_TAG  out  C_TAG_WIDTH  allocated PCIe tag
- RD_REQ_ADDR  out  64  address
- RD_REQ_LEN  out  10  length, passed through unchanged
- CPL_VALID  in  1  completion beat valid
- CPL_TAG  in  C_TAG_WIDTH  completion tag
- CPL_DATA  in  C_DATA_WIDTH  completion payload
- CPL_DATA_EN  in  3  valid dword count in beat, 0..4
- CPL_ERR  in  1  completion carries error status
- ENG_DATA  out  C_DATA_WIDTH  shared data bus to RX port
- MAIN_DATA_EN / SG_RX_DATA_EN / SG_TX_DATA_EN  out  3 each  dword enables per destination
- MAIN_DONE / SG_RX_DONE / SG_TX_DONE  out  1 each  tag completed
- MAIN_ERR / SG_RX_ERR / SG_TX_ERR  out  1 each  tag completed with error
- CPL_DROP  out  1  pulse: completion to an unallocated tag
- IDLE  out  1  no tags outstanding and request FSM idle

Behaviour:
- Reset (async):
  - Tag table cleared: all entries free.
  - FSM returns to IDLE.
  - All outputs are 0 except IDLE=1.
  - Reset mid-transfer discards all outstanding tags; completions arriving afterwards report CPL_DROP.
- Tag table entry:
  - valid: 1 bit.
  - dest: 2 bits.
  - rem: 11 bits, remaining dwords.
- Request FSM states: IDLE, ISSUE.
  - IDLE, RX_REQ=1, RX_REQ_TAG=3: pulse RX_REQ_ACK and drop the request (no RD_REQ). Stay in IDLE.
  - IDLE, RX_REQ=1, dest valid, at least one free tag:
    - Pulse RX_REQ_ACK.
    - Allocate the lowest-numbered free tag: valid=1, dest=RX_REQ_TAG, rem=LEN (0 is stored as 1024).
    - Register ADDR, LEN and tag onto the RD_REQ_* outputs.
    - Go to ISSUE.
  - IDLE, no free tag: no ACK. RX_REQ stays pending.
  - ISSUE: RD_REQ=1 with stable ADDR/LEN/TAG until the cycle RD_REQ_ACK=1, then RD_REQ=0 and go to IDLE.
  - Maximum accept rate: one request every 2 cycles.
- Completion path: one registered stage; outputs appear the cycle after CPL_VALID.
  - ENG_DATA is loaded with CPL_DATA on every CPL_VALID.
  - Enable strobes are 0 whenever there is no completion.
  - Valid tag, CPL_ERR=0, EN<=rem:
    - The destination's DATA_EN is set to CPL_DATA_EN.
    - rem is decremented by EN.
    - If the new rem is 0: destination DONE=1 in the same cycle as its DATA_EN, and the tag is freed.
  - Valid tag, CPL_ERR=1 or EN>rem:
    - All DATA_EN=0.
    - Destination DONE=1 and ERR=1 together.
    - Tag freed.
  - Unallocated tag: CPL_DROP=1 for one cycle; all enables 0; table unchanged.
  - CPL_DATA_EN=0 with a valid tag is a no-op; no DONE unless rem is already 0.
- Simultaneous events:
  - Retire and allocation in the same cycle: allocation uses the free vector from before the retire. A freed tag is available from the next cycle.
  - Allocation and completion on different tags in the same cycle are independent.
- Only one destination strobe set is active per cycle. DONE/ERR are single-cycle pulses.
- IDLE = (FSM==IDLE) and no entry valid.

Test Plan:
- Single request: RX_REQ TAG=0, ADDR=0x1000, LEN=8 → ACK pulse; RD_REQ TAG=0, LEN=8. Completions of EN=4 then EN=4 on tag 0 → MAIN_DATA_EN=4, 4, with MAIN_DONE on the second beat; IDLE returns to 1.
- Pool exhaustion: 8 requests with LEN=4 and no completions → 8 ACKs on tags 0..7; the 9th is held with no ACK. Complete tag 3 (EN=4) → SG/MAIN DONE; the 9th request is ACKed with RD_REQ_TAG=3.
- Interleaved destinations: tag0→SG_RX with LEN=6, tag1→SG_TX with LEN=2. Beats tag0 EN=4, tag1 EN=2, tag0 EN=2 → SG_RX_DATA_EN=4, SG_TX_DATA_EN=2 + SG_TX_DONE, SG_RX_DATA_EN=2 + SG_RX_DONE.
- Errors: CPL_ERR=1 on an allocated tag → DONE+ERR on its destination with no DATA_EN. EN=4 with rem=2 → DONE+ERR. Completion on a free tag → CPL_DROP=1, all strobes 0.
- Edge lengths and reset:
  - LEN=0 → 256 beats of EN=4; DONE only on the 256th beat.
  - RX_REQ_TAG=3 → ACK with no RD_REQ.
  - rRst asserted during ISSUE → all outputs 0 immediately and IDLE=1; a later completion on the old tag gives CPL_DROP.
